// File: rtl/core_seq_if.sv
// Host-side bundle for the core run sequencer: run descriptor and handshake in,
// per-cycle core instruction word and run status out.
interface core_seq_if #(parameter int addr_w = 11);
    logic              start;
    logic              mode;
    logic              acc;
    logic [addr_w-1:0] w_base;
    logic [addr_w-1:0] x_base;
    logic [addr_w-1:0] p_base;
    logic [addr_w-1:0] n_act;
    logic              ofifo_valid;
    logic [34:0]       inst;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, acc, w_base, x_base, p_base, n_act, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, mode, acc, w_base, x_base, p_base, n_act, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_seq.sv
// Run sequencer: expands one start request and descriptor into the 35-bit core
// instruction stream (weight load, activation stream, OFIFO drain to SRAM1).
module core_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11
) (
    input  logic       clk,
    input  logic       reset,
    core_seq_if.slave  bus
);
    localparam int          cw        = addr_w + 1;
    localparam logic [34:0] idle_word = 35'h3_0018_0000;

    typedef enum logic [2:0] {
        IDLE, W_RD, W_LD, W_DRAIN, X_RD, EXEC, READ, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [cw-1:0]     cnt_reg, cnt_next;
    logic              mode_reg, mode_next;
    logic              acc_reg, acc_next;
    logic [addr_w-1:0] w_base_reg, w_base_next;
    logic [addr_w-1:0] x_base_reg, x_base_next;
    logic [addr_w-1:0] p_base_reg, p_base_next;
    logic [addr_w-1:0] n_act_reg, n_act_next;
    logic [cw-1:0]     n_ext;
    logic              fire;
    logic [cw-1:0]     p_idx;
    logic [cw-1:0]     lim;
    logic [addr_w-1:0] base;
    logic [34:0]       inst_reg, inst_next;
    logic              busy_reg, done_reg;

    assign n_ext = {1'b0, n_act_reg};

    // cnt_reg indexes the word currently on inst; in READ it counts writes issued.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + cw'(1);
        mode_next   = mode_reg;
        acc_next    = acc_reg;
        w_base_next = w_base_reg;
        x_base_next = x_base_reg;
        p_base_next = p_base_reg;
        n_act_next  = n_act_reg;
        fire        = 1'b0;
        p_idx       = '0;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.start) begin
                    state_next  = W_RD;
                    mode_next   = bus.mode;
                    acc_next    = bus.acc;
                    w_base_next = bus.w_base;
                    x_base_next = bus.x_base;
                    p_base_next = bus.p_base;
                    n_act_next  = bus.n_act;
                end
            end
            W_RD: if (cnt_reg == cw'(row)) begin
                state_next = W_LD;
                cnt_next   = '0;
            end
            W_LD: if (cnt_reg == cw'(row - 1)) begin
                state_next = W_DRAIN;
                cnt_next   = '0;
            end
            W_DRAIN: if (cnt_reg == cw'(row + col - 1)) begin
                state_next = (n_act_reg == '0) ? DONE : X_RD;
                cnt_next   = '0;
            end
            X_RD: if (cnt_reg == n_ext) begin
                state_next = EXEC;
                cnt_next   = '0;
            end
            EXEC: if (cnt_reg == n_ext - cw'(1)) begin
                state_next = READ;
                cnt_next   = '0;
            end
            READ: begin
                if (cnt_reg == n_ext) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // The OFIFO is show-ahead, so a valid word is popped and written in one cycle.
        if (state_next == READ && bus.ofifo_valid) begin
            fire     = 1'b1;
            p_idx    = cnt_next;
            cnt_next = cnt_next + cw'(1);
        end
    end

    // Output word for the coming cycle, built from the next state so it can be registered.
    always_comb begin
        inst_next = idle_word;
        lim       = cw'(row);
        base      = w_base_next;
        if (state_next != IDLE)
            inst_next[2] = mode_next;
        case (state_next)
            W_RD, X_RD: begin
                if (state_next == X_RD) begin
                    lim  = {1'b0, n_act_next};
                    base = x_base_next;
                end
                if (cnt_next < lim) begin
                    inst_next[20]   = 1'b0;
                    inst_next[18:8] = base + cnt_next[addr_w-1:0];
                end
                // SRAM0 data lands one cycle after the read, so the FIFO write lags by one.
                if (cnt_next != '0) begin
                    if (mode_next) inst_next[6] = 1'b1;
                    else           inst_next[3] = 1'b1;
                end
            end
            W_LD, EXEC: begin
                if (state_next == W_LD) inst_next[0] = 1'b1;
                else                    inst_next[1] = 1'b1;
                if (mode_next) inst_next[5] = 1'b1;
                else           inst_next[4] = 1'b1;
            end
            READ: begin
                inst_next[34] = acc_next;
                if (fire) begin
                    inst_next[7]     = 1'b1;
                    inst_next[33]    = 1'b0;
                    inst_next[32]    = 1'b0;
                    inst_next[31:21] = p_base_next + p_idx[addr_w-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            acc_reg    <= 1'b0;
            w_base_reg <= '0;
            x_base_reg <= '0;
            p_base_reg <= '0;
            n_act_reg  <= '0;
            inst_reg   <= idle_word;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            acc_reg    <= acc_next;
            w_base_reg <= w_base_next;
            x_base_reg <= x_base_next;
            p_base_reg <= p_base_next;
            n_act_reg  <= n_act_next;
            inst_reg   <= inst_next;
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == DONE);
        end
    end

    assign bus.inst = inst_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: the expected instruction stream of each run is
// queued at start and popped against the DUT output every cycle.
module tb_core_seq;
    localparam int          ROW    = 8;
    localparam int          COL    = 8;
    localparam logic [34:0] IDLE_W = 35'h3_0018_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_seq_if #(.addr_w(11)) bus();

    core_seq #(.row(ROW), .col(COL), .addr_w(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [34:0] inst;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    bit   vpat[$];
    int   checks = 0;
    int   errors = 0;

    bit          r_mode, r_acc;
    logic [10:0] r_w, r_x, r_p, r_n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Field order from bit 34 down: acc, CEN_p, WEN_p, A_p, CEN_x, WEN_x, A_x,
    // ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, mode, execute, load.
    function automatic logic [34:0] mkw(input bit a, input bit cen_p, input bit wen_p,
                                        input logic [10:0] ap, input bit cen_x,
                                        input logic [10:0] ax, input bit ofrd,
                                        input bit ifwr, input bit ifrd, input bit l0rd,
                                        input bit l0wr, input bit md, input bit ex,
                                        input bit ld);
        return {a, cen_p, wen_p, ap, cen_x, 1'b1, ax, ofrd, ifwr, ifrd, l0rd, l0wr, md, ex, ld};
    endfunction

    function automatic exp_t mke(input logic [34:0] w, input bit b, input bit d);
        exp_t e;
        e.inst = w;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    task automatic push_rd(input logic [10:0] base, input int n);
        for (int k = 0; k <= n; k++) begin
            logic [10:0] ax;
            ax = (k < n) ? base + 11'(k) : 11'h0;
            exp_q.push_back(mke(mkw(0, 1, 1, 0, (k >= n), ax, 0, r_mode && k > 0, 0, 0,
                                    !r_mode && k > 0, r_mode, 0, 0), 1, 0));
        end
    endtask

    task automatic build_expect(output int len, output int r0);
        int i, j;
        exp_q.delete();
        push_rd(r_w, ROW);
        for (int k = 0; k < ROW; k++)
            exp_q.push_back(mke(mkw(0, 1, 1, 0, 1, 0, 0, 0, r_mode, !r_mode, 0, r_mode, 0, 1), 1, 0));
        for (int k = 0; k < ROW + COL; k++)
            exp_q.push_back(mke(mkw(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, r_mode, 0, 0), 1, 0));
        r0 = (ROW + 1) + ROW + (ROW + COL) + (int'(r_n) + 1) + int'(r_n);
        if (r_n != 0) begin
            push_rd(r_x, int'(r_n));
            for (int k = 0; k < int'(r_n); k++)
                exp_q.push_back(mke(mkw(0, 1, 1, 0, 1, 0, 0, 0, r_mode, !r_mode, 0, r_mode, 1, 0), 1, 0));
            i = 0;
            j = 0;
            while (j < int'(r_n)) begin
                if (vpat[i % vpat.size()]) begin
                    exp_q.push_back(mke(mkw(r_acc, 0, 0, r_p + 11'(j), 1, 0, 1, 0, 0, 0, 0, r_mode, 0, 0), 1, 0));
                    j++;
                end else begin
                    exp_q.push_back(mke(mkw(r_acc, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, r_mode, 0, 0), 1, 0));
                end
                i++;
            end
        end
        exp_q.push_back(mke(mkw(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, r_mode, 0, 0), 1, 1));
        len = exp_q.size();
        exp_q.push_back(mke(IDLE_W, 0, 0));
    endtask

    task automatic scramble();
        bus.mode   = 1'($urandom_range(0, 1));
        bus.acc    = 1'($urandom_range(0, 1));
        bus.w_base = 11'($urandom);
        bus.x_base = 11'($urandom);
        bus.p_base = 11'($urandom);
        bus.n_act  = 11'($urandom);
    endtask

    task automatic do_run(input string name, input bit noise, input bit hold, input int abort_t);
        int   len, r0, t, nt, done_cnt, rd_cnt, done_t;
        exp_t e;
        build_expect(len, r0);
        bus.mode   = r_mode;
        bus.acc    = r_acc;
        bus.w_base = r_w;
        bus.x_base = r_x;
        bus.p_base = r_p;
        bus.n_act  = r_n;
        bus.start  = 1'b1;
        bus.ofifo_valid = 1'b1;
        t = 0;
        done_cnt = 0;
        rd_cnt = 0;
        done_t = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s inst[%0d]", name, t), 64'(bus.inst), 64'(e.inst));
            chk($sformatf("%s busy_done[%0d]", name, t), 64'({bus.busy, bus.done}), 64'({e.busy, e.done}));
            if (bus.done) begin
                done_cnt++;
                done_t = t;
            end
            if (bus.inst[7]) rd_cnt++;
            if (t == abort_t) begin
                reset = 1'b0;
                #1;
                chk({name, " abort_inst"}, 64'(bus.inst), 64'(IDLE_W));
                chk({name, " abort_busy_done"}, 64'({bus.busy, bus.done}), 64'(0));
                exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    chk({name, " held_inst"}, 64'(bus.inst), 64'(IDLE_W));
                    if (bus.done) done_cnt++;
                end
                bus.start = 1'b0;
                reset = 1'b1;
                chk({name, " abort_done_count"}, 64'(done_cnt), 64'(0));
                $display("run %s: aborted at word %0d, done pulses %0d", name, t, done_cnt);
                return;
            end
            nt = t + 1;
            scramble();
            if (exp_q.size() == 0 || nt == len) bus.start = hold;
            else bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (r_n != 0 && nt >= r0) bus.ofifo_valid = vpat[(nt - r0) % vpat.size()];
            else bus.ofifo_valid = 1'($urandom_range(0, 1));
            t++;
        end
        chk({name, " done_count"}, 64'(done_cnt), 64'(1));
        chk({name, " run_length"}, 64'(done_t + 1), 64'(len));
        chk({name, " ofifo_rd_count"}, 64'(rd_cnt), 64'(r_n));
        $display("run %s: mode=%0d acc=%0d n_act=%0d length=%0d done_at=%0d ofifo_rd=%0d",
                 name, r_mode, r_acc, r_n, len, done_t + 1, rd_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b1;
        bus.ofifo_valid = 1'b1;
        scramble();
        repeat (4) begin
            @(negedge clk);
            scramble();
            bus.start = 1'($urandom_range(0, 1));
            chk("reset_inst", 64'(bus.inst), 64'(IDLE_W));
            chk("reset_busy_done", 64'({bus.busy, bus.done}), 64'(0));
        end
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            scramble();
            chk("post_reset_inst", 64'(bus.inst), 64'(IDLE_W));
            chk("post_reset_busy_done", 64'({bus.busy, bus.done}), 64'(0));
        end
        $display("reset phase: outputs held at idle word");

        r_mode = 0; r_acc = 0; r_w = 11'h010; r_x = 11'h100; r_p = 11'h040; r_n = 11'd4;
        vpat = '{1'b1};
        do_run("nominal", 1'b0, 1'b0, -1);

        r_mode = 1; r_acc = 1; r_w = 11'h020; r_x = 11'h200; r_p = 11'h080; r_n = 11'd4;
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_run("mode1_stall", 1'b1, 1'b0, -1);

        r_mode = 0; r_acc = 1; r_w = 11'h7FC; r_x = 11'h7FE; r_p = 11'h7FF; r_n = 11'd3;
        vpat = '{1'b1, 1'b1, 1'b0};
        do_run("wrap", 1'b1, 1'b0, -1);

        r_mode = 1; r_acc = 0; r_w = 11'h333; r_x = 11'h444; r_p = 11'h555; r_n = 11'd0;
        vpat = '{1'b1};
        do_run("empty_b2b", 1'b1, 1'b1, -1);

        r_mode = 0; r_acc = 1; r_w = 11'h001; r_x = 11'h002; r_p = 11'h003; r_n = 11'd2;
        vpat = '{1'b0, 1'b1};
        do_run("chained", 1'b0, 1'b0, -1);

        r_mode = 0; r_acc = 0; r_w = 11'h010; r_x = 11'h100; r_p = 11'h040; r_n = 11'd4;
        vpat = '{1'b1};
        do_run("abort_exec", 1'b0, 1'b0, 39);

        r_mode = 1; r_acc = 1; r_w = 11'h123; r_x = 11'h456; r_p = 11'h789; r_n = 11'd5;
        vpat = '{1'b1, 1'b1, 1'b0};
        do_run("after_abort", 1'b1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_seq.md
# core_seq

Run sequencer for the `core` datapath: turns a single `start` request plus a small descriptor into the per-cycle 35-bit `inst` word. The instruction stream loads one weight tile from SRAM0 through L0/IFIFO into the PE array and streams `n_act` activation vectors through it. It then drains the OFIFO into SRAM1 at consecutive psum addresses. Sits between the testbench/host and `core`, replacing hand-written instruction streams.

## Interface
- `row`, 8, PE array rows; also the number of weight words per tile
- `col`, 8, PE array columns; used for the pipeline drain count
- `addr_w`, 11, SRAM address width
- `clk` in 1: single clock; all flops rising-edge
- `reset` in 1: asynchronous, active-low; one clock, reset is asynchronous and active-low
- `start` in 1: run request, sampled only in IDLE
- `mode` in 1: 0 = activations via L0, 1 = via IFIFO; latched at start
- `acc` in 1: accumulate flag; latched at start
- `w_base` in addr_w: SRAM0 address of weight word 0
- `x_base` in addr_w: SRAM0 address of activation word 0
- `p_base` in addr_w: SRAM1 address of psum word 0
- `n_act` in addr_w: activation vector count; latched at start
- `ofifo_valid` in 1: OFIFO has a readable word
- `inst` out 35: core instruction word, using the standard field mapping (bit 34 acc … bit 0 load)
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at run end

## Operation
- All outputs are registered. Reset and IDLE value: `inst` = 35'h3_0018_0000 (CEN/WEN of both SRAMs = 1, all other bits 0), `busy`=0, `done`=0.
- CEN and WEN are active-low. SRAM read data is valid one cycle after CEN=0/WEN=1.
- OFIFO is show-ahead: data on `ofifo_rdata` is written in the same cycle `ofifo_rd`=1.
- `inst[2]` = latched mode for the whole run.
- The FIFO write strobe is l0_wr (inst[3]) when mode=0, ififo_wr (inst[6]) when mode=1. The FIFO read strobe is l0_rd (inst[4]) or ififo_rd (inst[5]) by the same rule.
- `inst[34]` = latched acc, driven only in READ.
- States and actions:
  - IDLE: `start`=1 latches the descriptor and moves to W_RD.
  - W_RD, row+1 cycles: at cycle k<row, CEN_x=0, WEN_x=1, A_x=w_base+k. At cycles 1..row, the FIFO write strobe is high.
  - W_LD, row cycles: load=1 and FIFO read strobe=1.
  - W_DRAIN, row+col cycles: idle word. If n_act=0, go to DONE; otherwise go to X_RD.
  - X_RD, n_act+1 cycles: same pattern as W_RD, using x_base and n_act.
  - EXEC, n_act cycles: execute=1 and FIFO read strobe=1.
  - READ: in any cycle with `ofifo_valid`=1, drive ofifo_rd=1, CEN_p=0, WEN_p=0, A_p=p_base+j, then j++. In cycles with `ofifo_valid`=0, drive the idle word (stall, no timeout). Exit after the n_act-th write.
  - DONE, 1 cycle: `done`=1, then IDLE.
- Address arithmetic is modulo 2^addr_w, so an address wraps from 2047 to 0.
- `start` outside IDLE is ignored and not queued. Descriptor changes after start have no effect.
- Asserting `reset` in any state returns the block to IDLE with reset output values immediately. The partial run is abandoned with no done pulse.

## Timing
- Start is sampled at edge E0; the W_RD first word appears after E0.
- Run length = (row+1) + row + (row+col) + (n_act+1) + n_act + R + 1 cycles, where R = READ cycles (≥ n_act).
- Example: row=col=8, n_act=4, ofifo_valid held high gives 47 cycles from E0 to the end of the done pulse.
- Back-to-back runs: `start` held high across DONE begins a new run on the cycle after DONE (one IDLE cycle).

## Test plan
- Reset: hold `reset`=0 with random inputs → `inst`=35'h3_0018_0000, busy=0, done=0. Release → outputs unchanged until start.
- Nominal run, mode=0, w_base=0x010, x_base=0x100, p_base=0x040, n_act=4, ofifo_valid=1:
  - A_x sequence 0x010..0x017, then 0x100..0x103, each followed one cycle later by l0_wr.
  - 8 load cycles; 4 execute cycles.
  - SRAM1 writes at 0x040..0x043.
  - done at cycle 47.
- Mode=1, acc=1, with ofifo_valid toggling 1,0,0,1,1,0,1:
  - ififo_wr/ififo_rd are used in place of l0_wr/l0_rd.
  - No ofifo_rd occurs while valid=0; exactly 4 writes; inst[34]=1 during READ.
- Wrap and empty run:
  - x_base=0x7FE, n_act=3 → A_x 0x7FE, 0x7FF, 0x000.
  - n_act=0 → DONE directly after W_DRAIN, with no execute or ofifo_rd.
- Start pulses during busy → ignored: exactly one done, addresses unchanged.
- Reset asserted mid-EXEC → inst returns to the idle word in the same cycle, no done pulse. A subsequent start runs cleanly.
